// File: rtl/phase_sequencer.sv
// phase_sequencer: multi-cycle control FSM for the MIPS core.
// Issues single-cycle enables to the IR, register file and PC, and handshakes
// with the memory port for instruction fetch and load/store access.
// Optional build macro PHASE_SEQ_TIMEOUT_EN adds a memory-ack watchdog that
// halts the sequencer and raises a sticky err flag. Without the macro, the
// sequencer waits for mem_ack indefinitely and err is tied low.
module phase_sequencer #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic             stall,
    input  logic             is_mem,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             ifetch,
    output logic             ir_en,
    output logic             reg_en,
    output logic             pc_en,
    output logic             busy,
    output logic             err,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        DMEM   = 3'd3,
        WB     = 3'd4,
        PCUPD  = 3'd5,
        HALTED = 3'd6
    } state_t;

    state_t state;
    state_t next_state;
    logic   count_inc;
    logic   timeout_hit;

    // Reject out-of-range timeout values at elaboration time.
    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 65535) begin : g_bad_timeout
        $error("phase_sequencer: MEM_TIMEOUT must be in 1..65535");
    end

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and enable decode. Stall freezes only the non-memory states,
    // so an in-flight memory access always completes.
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        ifetch     = 1'b0;
        ir_en      = 1'b0;
        reg_en     = 1'b0;
        pc_en      = 1'b0;
        count_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                ifetch  = 1'b1;
                if (mem_ack) begin
                    ir_en      = 1'b1;
                    next_state = DECODE;
                end else if (timeout_hit) begin
                    next_state = HALTED;
                end
            end
            DECODE: begin
                if (!stall) next_state = is_mem ? DMEM : WB;
            end
            DMEM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    next_state = WB;
                end else if (timeout_hit) begin
                    next_state = HALTED;
                end
            end
            WB: begin
                if (!stall) begin
                    reg_en     = 1'b1;
                    next_state = PCUPD;
                end
            end
            PCUPD: begin
                if (!stall) begin
                    pc_en      = 1'b1;
                    count_inc  = 1'b1;
                    next_state = halt_req ? HALTED : FETCH;
                end
            end
            HALTED: begin
                if (start) next_state = FETCH;
            end
            default: next_state = IDLE;
        endcase
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if (count_inc) begin
            instr_count <= instr_count + 1'b1;
        end
    end

    assign phase = state;
    assign busy  = (state != IDLE) && (state != HALTED);

`ifdef PHASE_SEQ_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    logic [15:0] wait_cnt;
    logic        err_q;

    assign timeout_hit = ((state == FETCH) || (state == DMEM)) && !mem_ack
                         && (wait_cnt == WAIT_LAST);

    // Wait counter restarts on every state change and counts unacked cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (next_state != state) begin
            wait_cnt <= '0;
        end else if (((state == FETCH) || (state == DMEM)) && !mem_ack) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // Sticky timeout flag, cleared when execution is restarted from HALTED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end else if ((state == HALTED) && start) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

endmodule
